// File: rtl/dsm_modulator.sv
// Second-order 1-bit delta-sigma modulator with ZOH interpolation by M.
// Optional LSB dither via LFSR when DSM_DITHER_EN is defined.
module dsm_modulator #(
  parameter int INPUT_BITS = 16,
  parameter int M          = 16,
  parameter int ACC_W      = INPUT_BITS + 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [INPUT_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode_inc,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);
  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (INPUT_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [INPUT_BITS-1:0]   next_buf;
  logic                    next_full;
  logic [INPUT_BITS-1:0]   cur;
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] i1;
  logic signed [ACC_W-1:0] i2;
  logic                    mode;

  logic                    take;
  logic                    at_last;
  logic                    start;
  logic                    drain;
  logic                    mode_d;
  logic                    dith;
  logic                    y;
  logic signed [ACC_W-1:0] u;
  logic signed [ACC_W-1:0] v;
  logic signed [ACC_W-1:0] i1_nx;
  logic signed [ACC_W-1:0] i2_nx;

  assign in_ready = ~next_full;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr;
  logic        fb;

  assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dith = lfsr[0];

  // Dither source: steps once per output bit, reseeded on reset/clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (clear) begin
      lfsr <= 16'hACE1;
    end else if (state_q == RUN) begin
      lfsr <= {lfsr[14:0], fb};
    end
  end
`else
  assign dith = 1'b0;
`endif

  // Handshake, frame boundary and loop arithmetic.
  always_comb begin
    take    = in_valid & ~next_full;
    at_last = (state_q == RUN) && (cnt == LAST);
    start   = (state_q == IDLE) && next_full;
    drain   = start | (at_last & next_full);
    mode_d  = (start | at_last) ? mode_inc : mode;
    u       = $signed({{(ACC_W-INPUT_BITS){1'b0}}, cur})
            - HALF + ACC_W'(dith);
    y       = ~i2[ACC_W-1];
    v       = y ? HALF : -HALF;
    i1_nx   = i1 + u - v;
    i2_nx   = i2 + i1 - v - v;
  end

  // Next state: leave IDLE once a sample is buffered.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer, integrators, frame counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_buf    <= '0;
      next_full   <= 1'b0;
      cur         <= '0;
      cnt         <= '0;
      i1          <= '0;
      i2          <= '0;
      mode        <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (clear) begin
      next_full   <= 1'b0;
      cnt         <= '0;
      i1          <= '0;
      i2          <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (take) begin
        next_buf  <= in_data;
        next_full <= 1'b1;
      end
      if (drain) begin
        cur       <= next_buf;
        next_full <= 1'b0;
      end
      mode     <= mode_d;
      underrun <= at_last & ~next_full;
      if (state_q == RUN) begin
        bit_out     <= y;
        bit_valid   <= 1'b1;
        frame_start <= (cnt == '0);
        cnt         <= at_last ? '0 : cnt + 1'b1;
        if (at_last && mode_d) begin
          i1 <= '0;
          i2 <= '0;
        end else begin
          i1 <= i1_nx;
          i2 <= i2_nx;
        end
      end else begin
        bit_valid   <= 1'b0;
        frame_start <= 1'b0;
        cnt         <= '0;
        i1          <= '0;
        i2          <= '0;
      end
    end
  end

endmodule
